bank_register_dumper: RTL and testbench

Debug-side reader for the ID-stage register bank. While the pipeline is halted, it walks registers 0..BANK_SIZE-1 through the bank's debug read port (read enable plus read address), captures each word, and serializes it MSB-byte-first to the debug UART transmitter with a start/done handshake. It sits inside the Debug Unit, between the bank and the UART TX.

---
 rtl/bank_register_dumper_pkg.sv | 27 ++
 rtl/bank_register_dumper_serializer.sv | 42 ++++
 rtl/bank_register_dumper.sv | 110 +++++++++++
 tb/tb_bank_register_dumper.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_register_dumper_pkg.sv
// Shared Debug Unit definitions: dump FSM state encodings and word/byte sizing helpers.
// Imported by the register-bank dumper and the reusable word serializer.
package bank_register_dumper_pkg;

  localparam int DEFAULT_BYTE_SIZE = 8;
  localparam int DEFAULT_DATA_SIZE = 32;
  localparam int BYTES_PER_WORD    = DEFAULT_DATA_SIZE / DEFAULT_BYTE_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } dumpState_t;

  function automatic int bytesPerWord(input int dataSize, input int byteSize);
    return dataSize / byteSize;
  endfunction

  // A single-byte word still needs a 1-bit counter so the port widths stay legal.
  function automatic int counterWidth(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/bank_register_dumper_serializer.sv
// Word-to-byte serializer: captures a word and presents it MSB byte first.
// Also used by the Debug Unit for PC and data-memory dumps.
module debug_word_serializer
  import bank_register_dumper_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic                 i_next,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic [BYTE_SIZE-1:0] o_byte,
  output logic                 o_last
);

  localparam int BPW   = bytesPerWord(DATA_SIZE, BYTE_SIZE);
  localparam int CNT_W = counterWidth(BPW);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BPW - 1);

  logic [DATA_SIZE-1:0] r_shift;
  logic [CNT_W-1:0]     r_count;

  // Loading a new word also restarts the byte count; shifting fills with zeros.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_count <= '0;
    end else if (i_next) begin
      r_shift <= r_shift << BYTE_SIZE;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_byte = r_shift[DATA_SIZE-1 -: BYTE_SIZE];
  assign o_last = (r_count == LAST_COUNT);

endmodule

// File: rtl/bank_register_dumper.sv
// Debug-side register bank dumper: walks every register through the debug read
// port and streams each word MSB byte first to the UART TX with a start/done handshake.
module bank_register_dumper
  import bank_register_dumper_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int REG_SIZE  = 5,
  parameter int BANK_SIZE = 32,
  parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_rd_data,
  input  logic                 i_tx_done,
  output logic                 o_read_enable,
  output logic [REG_SIZE-1:0]  o_read_addr,
  output logic                 o_tx_start,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [REG_SIZE-1:0] LAST_ADDR = REG_SIZE'(BANK_SIZE - 1);

  dumpState_t          r_state;
  dumpState_t          w_nextState;
  logic [REG_SIZE-1:0] r_addr;
  logic                w_load;
  logic                w_next;
  logic                w_addrClear;
  logic                w_addrInc;
  logic                w_lastByte;
  logic [BYTE_SIZE-1:0] w_byte;

  debug_word_serializer #(
    .DATA_SIZE(DATA_SIZE),
    .BYTE_SIZE(BYTE_SIZE)
  ) u_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_next  (w_next),
    .i_data  (i_rd_data),
    .o_byte  (w_byte),
    .o_last  (w_lastByte)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The address is compared against the last register before incrementing, so it never wraps.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_addrClear) begin
      r_addr <= '0;
    end else if (w_addrInc) begin
      r_addr <= r_addr + REG_SIZE'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_next      = 1'b0;
    w_addrClear = 1'b0;
    w_addrInc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_addrClear = 1'b1;
          w_nextState = ST_REQ;
        end
      end
      ST_REQ:  w_nextState = ST_WAIT;
      ST_WAIT: begin
        w_load      = 1'b1;
        w_nextState = ST_SEND;
      end
      ST_SEND: w_nextState = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (!w_lastByte) begin
            w_next      = 1'b1;
            w_nextState = ST_SEND;
          end else if (r_addr == LAST_ADDR) begin
            w_nextState = ST_DONE;
          end else begin
            w_addrInc   = 1'b1;
            w_nextState = ST_REQ;
          end
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign o_read_enable = (r_state == ST_REQ);
  assign o_read_addr   = o_read_enable ? r_addr : '0;
  assign o_tx_start    = (r_state == ST_SEND);
  assign o_tx_data     = w_byte;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_bank_register_dumper.sv
// Self-checking bench for bank_register_dumper: event-timed behavioural model of a
// full register dump, a registered bank model and a UART TX ack model with noise.
module tb_bank_register_dumper;

  localparam int DATA_SIZE   = 32;
  localparam int REG_SIZE    = 5;
  localparam int BANK_SIZE   = 32;
  localparam int BYTE_SIZE   = 8;
  localparam int BPW         = DATA_SIZE / BYTE_SIZE;
  localparam int TOTAL_BYTES = BANK_SIZE * BPW;
  localparam int TIMEOUT     = 3000;

  logic                 i_clock = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_start = 1'b0;
  logic                 i_tx_done = 1'b0;
  logic [DATA_SIZE-1:0] bankData = '0;
  logic                 o_read_enable;
  logic [REG_SIZE-1:0]  o_read_addr;
  logic                 o_tx_start;
  logic [BYTE_SIZE-1:0] o_tx_data;
  logic                 o_busy;
  logic                 o_done;

  bank_register_dumper #(
    .DATA_SIZE(DATA_SIZE),
    .REG_SIZE (REG_SIZE),
    .BANK_SIZE(BANK_SIZE),
    .BYTE_SIZE(BYTE_SIZE)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_rd_data    (bankData),
    .i_tx_done    (i_tx_done),
    .o_read_enable(o_read_enable),
    .o_read_addr  (o_read_addr),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clock = ~i_clock;

  // Register bank with a registered debug read port.
  logic [DATA_SIZE-1:0] regs [BANK_SIZE];
  always @(posedge i_clock) begin
    if (o_read_enable) bankData <= regs[o_read_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // Model of the dump, expressed as the cycle on which each event is due.
  int cyc = 0;
  bit mBusy = 0;
  int expRead = -1, expSend = -1, expDone = -1;
  int readsSeen = 0, byteIdx = 0;
  bit outstanding = 0;
  int sendCycle = 0, ackCycle = 0;
  bit zeroCheck = 0;
  bit eRe, eSt, eDn;

  int ackDelay = 3;
  bit txNoise = 0, startNoise = 0;

  logic [7:0] captured [256];
  logic [7:0] baseCap [TOTAL_BYTES];
  int nCap, doneCount, nReads, startCycle, firstSendCycle;
  int readCycle [40];

  function automatic logic [7:0] expByte(input int idx);
    logic [DATA_SIZE-1:0] w;
    w = regs[idx / BPW];
    return w[BYTE_SIZE*(BPW-1-(idx % BPW)) +: BYTE_SIZE];
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkOutput();
    eRe = (cyc == expRead);
    eSt = (cyc == expSend);
    eDn = (cyc == expDone);
    check("read_enable", {31'd0, o_read_enable}, {31'd0, eRe});
    check("tx_start", {31'd0, o_tx_start}, {31'd0, eSt});
    check("done", {31'd0, o_done}, {31'd0, eDn});
    check("busy", {31'd0, o_busy}, {31'd0, mBusy});
    if (eRe) check("read_addr", {27'd0, o_read_addr}, readsSeen);
    if ((eSt || outstanding) && byteIdx < TOTAL_BYTES)
      check("tx_data", {24'd0, o_tx_data}, {24'd0, expByte(byteIdx)});
    if (zeroCheck) begin
      check("reset_tx_data", {24'd0, o_tx_data}, 32'd0);
      check("reset_read_addr", {27'd0, o_read_addr}, 32'd0);
      zeroCheck = 0;
    end
    if (o_tx_start && nCap < 256) begin
      if (nCap == 0) firstSendCycle = cyc;
      captured[nCap] = o_tx_data;
      nCap++;
    end
    if (o_read_enable && nReads < 40) begin
      readCycle[nReads] = cyc;
      nReads++;
    end
    if (o_done) doneCount++;
  endtask

  task automatic applyStimulus(input bit startReq, input bit resetReq);
    bit waiting;
    waiting = outstanding && (cyc > sendCycle);
    i_reset = resetReq;
    i_start = startReq || (startNoise && mBusy && ($urandom_range(0, 3) == 0));
    if (waiting) i_tx_done = (cyc == ackCycle);
    else         i_tx_done = txNoise && ($urandom_range(0, 2) == 0);
  endtask

  task automatic updateModel();
    bit busyNow;
    busyNow = mBusy;
    if (i_reset) begin
      mBusy = 0; expRead = -1; expSend = -1; expDone = -1;
      outstanding = 0; zeroCheck = 1;
      return;
    end
    if (eDn) mBusy = 0;
    if (!busyNow && i_start) begin
      mBusy = 1; expRead = cyc + 1; readsSeen = 0; byteIdx = 0; startCycle = cyc;
    end
    if (eRe) begin
      readsSeen++;
      expSend = cyc + 2;
    end
    if (eSt) begin
      outstanding = 1;
      sendCycle = cyc;
      ackCycle = cyc + ((ackDelay > 0) ? ackDelay : int'($urandom_range(1, 4)));
    end else if (outstanding && cyc > sendCycle && i_tx_done) begin
      outstanding = 0;
      byteIdx++;
      if (byteIdx % BPW != 0)          expSend = cyc + 1;
      else if (byteIdx == TOTAL_BYTES) expDone = cyc + 1;
      else                             expRead = cyc + 1;
    end
  endtask

  task automatic runCycle(input bit startReq, input bit resetReq);
    checkOutput();
    applyStimulus(startReq, resetReq);
    updateModel();
    @(posedge i_clock);
    #1;
    cyc++;
  endtask

  task automatic clearCapture();
    nCap = 0; doneCount = 0; nReads = 0; firstSendCycle = -1;
  endtask

  task automatic runDump();
    int n;
    clearCapture();
    runCycle(1, 0);
    n = 0;
    while (mBusy && n < TIMEOUT) begin
      runCycle(0, 0);
      n++;
    end
    vectors++;
    if (mBusy) begin
      miscompares++;
      $display("[TB] FAIL dump_timeout: still busy after %0d cycles, required idle", n);
    end
    for (int i = 0; i < 3; i++) runCycle(0, 0);
  endtask

  task automatic checkDumpTotals(input string tag);
    check({tag, "_bytes"}, nCap, TOTAL_BYTES);
    check({tag, "_done_count"}, doneCount, 1);
    check({tag, "_reads"}, nReads, BANK_SIZE);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int litIdx [12];
    logic [7:0] litVal [12];
    litIdx = '{0, 1, 2, 3, 4, 5, 6, 7, 124, 125, 126, 127};
    litVal = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01,
               8'h1F, 8'h00, 8'h00, 8'h1F};
    for (int n = 0; n < BANK_SIZE; n++) regs[n] = 32'h0100_0000 * n + n;

    repeat (3) @(posedge i_clock);
    #1;
    zeroCheck = 1;
    clearCapture();
    runCycle(0, 0);

    // Base run: ack three cycles after every start.
    ackDelay = 3; txNoise = 0; startNoise = 0;
    runDump();
    checkDumpTotals("base");
    for (int i = 0; i < 12; i++)
      check($sformatf("base_byte%0d", litIdx[i]), {24'd0, captured[litIdx[i]]}, {24'd0, litVal[i]});
    for (int i = 0; i < TOTAL_BYTES; i++) baseCap[i] = captured[i];

    // Spurious acks in SEND/REQ/WAIT/IDLE must not advance the stream.
    txNoise = 1;
    runDump();
    checkDumpTotals("noise");
    for (int i = 0; i < TOTAL_BYTES; i++)
      check($sformatf("noise_byte%0d", i), {24'd0, captured[i]}, {24'd0, baseCap[i]});

    // Back-to-back acks: minimum latency and 10-cycle register period.
    txNoise = 0; ackDelay = 1;
    runDump();
    checkDumpTotals("b2b");
    check("first_send_latency", firstSendCycle - startCycle, 3);
    for (int i = 1; i < BANK_SIZE; i++)
      check($sformatf("reg_period%0d", i), readCycle[i] - readCycle[i-1], 10);

    // Repeated start pulses while busy are ignored.
    ackDelay = 2; startNoise = 1;
    runDump();
    checkDumpTotals("restart");
    startNoise = 0;

    // Abort with reset after 50 bytes, then restart from reg0 MSB.
    ackDelay = 2;
    clearCapture();
    runCycle(1, 0);
    for (int n = 0; n < TIMEOUT && byteIdx < 50; n++) runCycle(0, 0);
    check("bytes_before_reset", byteIdx, 50);
    runCycle(0, 1);
    for (int i = 0; i < 10; i++) runCycle(0, 0);
    check("abort_done_count", doneCount, 0);
    runDump();
    checkDumpTotals("after_reset");
    check("after_reset_first_byte", {24'd0, captured[0]}, 32'd0);

    // Random bank contents, random ack latency, noise on both inputs.
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < BANK_SIZE; n++) regs[n] = $urandom;
      ackDelay = 0; txNoise = 1; startNoise = 1;
      runDump();
      checkDumpTotals("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
